shift_reg_collect: RTL and testbench
====================================

Name: shift_reg_collect

Overview:
- Serial-to-parallel collector: accepts one signed 8-bit element per handshake and assembles DEPTH elements into one parallel word.
- Mirror of the PE-side serializer; first element received lands in lane 0, matching the serializer's output order.
- Buffered in two stages, a collect buffer plus an output holding register, so streaming continues while the downstream consumer holds a finished word.

Parameters:
- DEPTH, 32, elements per assembled word.
- WIDTH, 8, bits per element (signed).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- clear  input  1  synchronous drop of the partial word in progress.
- in_data  input  signed [WIDTH-1:0]  serial element.
- in_valid  input  1  in_data valid.
- in_ready  output  1  collector can accept an element.
- out_data  output  signed [WIDTH-1:0] x [DEPTH-1:0]  assembled word; lane i = i-th accepted element.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes the word.
- count  output  [$clog2(DEPTH):0]  elements held in collect buffer (0..DEPTH).

Behaviour:
- accept = in_valid && in_ready. drain = out_valid && out_ready.
- States:
  - COLLECT: in_ready=1.
  - STALL: in_ready=0. Collect buffer is full and holding register is occupied.
- Reset (reset==0, async, no clock edge needed):
  - state=COLLECT, count=0, out_valid=0.
  - All out_data lanes=0, all buffer lanes=0.
  - in_ready reads 1.
- COLLECT, accept with count<DEPTH-1: buf[count]<=in_data; count<=count+1.
- COLLECT, accept with count==DEPTH-1 (word completes):
  - If !out_valid || drain: out_data<=buf with lane DEPTH-1=in_data; out_valid<=1; count<=0; stay COLLECT.
  - Else: buf[DEPTH-1]<=in_data; count<=DEPTH; go to STALL.
- STALL, on drain: out_data<=buf; out_valid stays 1; count<=0; go to COLLECT.
- out_valid falls only on a drain edge where no new word loads at the same edge.
- Latency: completed word appears on out_valid/out_data the cycle after the final accept.
- Full throughput: with out_ready=1, in_ready never deasserts; one word every DEPTH accepts.
- out_data and out_valid stay stable while out_valid && !out_ready.
- in_valid bubbles: element order and lane placement are unaffected by gaps.
- clear (sync, priority over accept; reset dominates everything):
  - count<=0, state<=COLLECT.
  - An element accepted in the same cycle is discarded.
  - Holding register and out_valid are unaffected; a drain in that cycle still completes.
- Partial words are never emitted. Unwritten buffer lanes hold stale values, but are always overwritten before a word is emitted.
- Arithmetic: data is passed through bit-exact (no sign extension, no saturation). count never exceeds DEPTH.
- Reset mid-word or mid-STALL: all state is discarded; no word is emitted.

Test Plan:
- Reset, then stream 0..31 back-to-back with out_ready=1 -> out_valid=1 one cycle after 32nd accept; out_data[i]=i; count returns to 0; in_ready stays 1 throughout.
- Two words -128..-97 then 1..32, contiguous in_valid, out_ready=1 -> in_ready never 0; out_valid pulses exactly 32 cycles apart; lanes exact, including negatives.
- out_ready=0, then send 64 elements -> word1 held on out_data; after 64th accept state=STALL, in_ready=0, count=32. Raise out_ready for 1 cycle -> word2 on out_data next cycle with out_valid=1, count=0, in_ready=1. Raise out_ready again -> out_valid=0.
- Send 10 elements (100..109), pulse clear, then send 200..231 -> emitted word lane0=200 ... lane31=231; no trace of 100..109. Accept coincident with clear is dropped.
- Random in_valid bubbles (~50%) carrying 0..31 -> identical word to the contiguous case.
- Drive reset=0 asynchronously mid-word, and again while out_valid=1 with out_ready=0 -> out_valid, count and all out_data lanes go to 0 before the next clk edge; after release, a fresh 32-element word assembles correctly.

Source files
------------

// File: rtl/shift_reg_collect_if.sv
// rtl/shift_reg_collect_if.sv - serial-in / parallel-out handshake bundle for the collector
interface shift_reg_collect_if #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH);

    logic [WIDTH-1:0]            in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [DEPTH-1:0][WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [CW:0]                 count;

    // Producer of serial elements and consumer of assembled words
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    // The collector itself
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/shift_reg_collect.sv
// rtl/shift_reg_collect.sv - serial-to-parallel collector with collect buffer and output holding register
module shift_reg_collect #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    shift_reg_collect_if.slave bus
);
    localparam int          CW     = $clog2(DEPTH);
    localparam logic [CW:0] C_LAST = (CW + 1)'(DEPTH - 1);
    localparam logic [CW:0] C_FULL = (CW + 1)'(DEPTH);
    localparam logic [CW:0] C_ONE  = (CW + 1)'(1);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_STALL   = 1'b1
    } state_t;

    state_t                      r_state;
    logic                        r_in_ready;
    logic [CW:0]                 r_count;
    logic [DEPTH-1:0][WIDTH-1:0] r_buf;
    logic [DEPTH-1:0][WIDTH-1:0] r_out_data;
    logic                        r_out_valid;

    logic                        w_accept;
    logic                        w_drain;
    logic [DEPTH-1:0][WIDTH-1:0] w_word;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_drain  = r_out_valid && bus.out_ready;

    // Completed word: buffered lanes plus the element arriving on the final accept
    always_comb begin
        w_word          = r_buf;
        w_word[DEPTH-1] = bus.in_data;
    end

    // Collector FSM: fills the buffer, hands words to the holding register, stalls when both are full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_COLLECT;
            r_in_ready  <= 1'b1;
            r_count     <= '0;
            r_buf       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // A drain empties the holding register unless a new word lands at the same edge
            if (w_drain) begin
                r_out_valid <= 1'b0;
            end

            if (clear) begin
                r_state    <= S_COLLECT;
                r_in_ready <= 1'b1;
                r_count    <= '0;
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_accept) begin
                            if (r_count < C_LAST) begin
                                r_buf[r_count[CW-1:0]] <= bus.in_data;
                                r_count                <= r_count + C_ONE;
                            end else if (!r_out_valid || w_drain) begin
                                r_out_data  <= w_word;
                                r_out_valid <= 1'b1;
                                r_count     <= '0;
                            end else begin
                                r_buf[DEPTH-1] <= bus.in_data;
                                r_count        <= C_FULL;
                                r_state        <= S_STALL;
                                r_in_ready     <= 1'b0;
                            end
                        end
                    end
                    S_STALL: begin
                        if (w_drain) begin
                            r_out_data  <= r_buf;
                            r_out_valid <= 1'b1;
                            r_count     <= '0;
                            r_state     <= S_COLLECT;
                            r_in_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state    <= S_COLLECT;
                        r_in_ready <= 1'b1;
                        r_count    <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.count     = r_count;
endmodule

// File: tb/tb_shift_reg_collect.sv
// tb/tb_shift_reg_collect.sv - scoreboard bench for shift_reg_collect
module tb_shift_reg_collect;
    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH);

    typedef logic [DEPTH-1:0][WIDTH-1:0] word_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;

    int    vectors     = 0;
    int    miscompares = 0;
    word_t sb[$];

    shift_reg_collect_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    shift_reg_collect #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Every drain takes one distinct word; compare it against the oldest expected word
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_word got=%h", bus.out_data);
            end else begin
                word_t exp;
                exp = sb.pop_front();
                if (bus.out_data !== exp) begin
                    miscompares++;
                    $display("FAIL word_data got=%h exp=%h", bus.out_data, exp);
                end
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] d);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout in_ready=%b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        #12;
        vectors += 4;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        if (bus.count !== '0) begin miscompares++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        word_t w;
        for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(i);
        sb.push_back(w);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, bus.in_ready); end
            send(WIDTH'(i));
        end
        vectors += 2;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_latency out_valid=%b exp=1", bus.out_valid); end
        if (bus.count !== '0) begin miscompares++; $display("FAIL stream_count got=%0d exp=0", bus.count); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_valid_fall got=%b exp=0", bus.out_valid); end
        wait_drained(4);
    endtask

    task automatic test_back_to_back();
        word_t w1, w2;
        int pulses, first_k, last_k;
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = WIDTH'(-128 + i);
            w2[i] = WIDTH'(1 + i);
        end
        sb.push_back(w1);
        sb.push_back(w2);
        bus.out_ready = 1'b1;
        pulses = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            vectors++;
            if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            send(k < DEPTH ? w1[k] : w2[k - DEPTH]);
            if (bus.out_valid === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
                last_k = k;
            end
        end
        vectors += 2;
        if (pulses != 2) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
        if (last_k - first_k != DEPTH) begin miscompares++; $display("FAIL b2b_spacing got=%0d exp=%0d", last_k - first_k, DEPTH); end
        wait_drained(4);
    endtask

    task automatic test_stall();
        word_t w1, w2;
        for (int i = 0; i < DEPTH; i++) begin
            w1[i] = WIDTH'(64 + i);
            w2[i] = WIDTH'(8'hc0 + i);
        end
        sb.push_back(w1);
        sb.push_back(w2);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2 * DEPTH; k++) send(k < DEPTH ? w1[k] : w2[k - DEPTH]);
        vectors += 4;
        if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
        if (bus.count !== (CW + 1)'(DEPTH)) begin miscompares++; $display("FAIL stall_count got=%0d exp=%0d", bus.count, DEPTH); end
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== w1) begin miscompares++; $display("FAIL stall_hold got=%h exp=%h", bus.out_data, w1); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        vectors += 4;
        if (bus.out_data !== w2) begin miscompares++; $display("FAIL stall_word2 got=%h exp=%h", bus.out_data, w2); end
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_word2_valid got=%b exp=1", bus.out_valid); end
        if (bus.count !== '0) begin miscompares++; $display("FAIL stall_release_count got=%0d exp=0", bus.count); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_final_valid got=%b exp=0", bus.out_valid); end
        wait_drained(4);
    endtask

    task automatic test_clear();
        word_t w;
        for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(200 + i);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(WIDTH'(100 + i));
        vectors++;
        if (bus.count !== (CW + 1)'(10)) begin miscompares++; $display("FAIL clear_precount got=%0d exp=10", bus.count); end
        clear = 1'b1;
        send(WIDTH'(99));
        clear = 1'b0;
        vectors++;
        if (bus.count !== '0) begin miscompares++; $display("FAIL clear_count got=%0d exp=0", bus.count); end
        sb.push_back(w);
        for (int i = 0; i < DEPTH; i++) send(w[i]);
        wait_drained(4);
    endtask

    task automatic test_bubbles();
        word_t w;
        int sent, guard;
        for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(i);
        sb.push_back(w);
        bus.out_ready = 1'b1;
        sent = 0; guard = 0;
        while (sent < DEPTH && guard < 1000) begin
            if ($urandom_range(1, 0) == 1) begin
                send(w[sent]);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = WIDTH'($urandom);
                @(posedge clk);
                #1;
            end
            guard++;
        end
        wait_drained(4);
    endtask

    task automatic test_async_reset();
        word_t w, f;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(WIDTH'(50 + i));
        #3 reset = 1'b0;
        #1;
        vectors += 3;
        if (bus.count !== '0) begin miscompares++; $display("FAIL areset_mid_count got=%0d exp=0", bus.count); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_mid_valid got=%b exp=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_mid_ready got=%b exp=1", bus.in_ready); end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) w[i] = WIDTH'(5 + i);
        bus.out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(w[i]);
        vectors += 2;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_held_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== w) begin miscompares++; $display("FAIL areset_held_data got=%h exp=%h", bus.out_data, w); end
        #3 reset = 1'b0;
        #1;
        vectors += 3;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_hold_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL areset_hold_data got=%h exp=0", bus.out_data); end
        if (bus.count !== '0) begin miscompares++; $display("FAIL areset_hold_count got=%0d exp=0", bus.count); end
        #1 reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) f[i] = WIDTH'(8'hf0 - i);
        sb.push_back(f);
        for (int i = 0; i < DEPTH; i++) send(f[i]);
        wait_drained(4);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_back_to_back();
        test_stall();
        test_clear();
        test_bubbles();
        test_async_reset();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
